// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = serial_sub_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );

endinterface

// File: rtl/full_adder.sv
// Single-bit full-adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, LSB first,
// computed as a + ~b + ~bin through one full-adder cell.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | one operand bit consumed per clock
// DONE  | one-cycle result-valid pulse; a new start is accepted here
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic           clk,
  input logic           rst,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Partial result; the final bit joins it directly on the way into diff.
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic             fa_sum;
  logic             fa_cout;
  logic             load_op;
  logic [WIDTH-1:0] shifted;

  full_adder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign load_op = bus.start && (state_q != SHIFT);
  assign shifted = {fa_sum, res_q};

  // Next-state, datapath shifting and result capture.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.start) state_d = SHIFT;
      end
      SHIFT: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        carry_d = fa_cout;
        res_d   = shifted[WIDTH-1:1];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          diff_d  = shifted;
          // Inverted carry-out is the unsigned borrow; carry_q here is the
          // carry into the MSB, so their XOR flags signed overflow.
          bout_d  = ~fa_cout;
          ovf_d   = carry_q ^ fa_cout;
        end
      end
      DONE: begin
        state_d = bus.start ? SHIFT : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load_op) begin
      a_sr_d  = bus.a;
      b_sr_d  = ~bus.b;
      carry_d = ~bus.bin;
      cnt_d   = '0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=4.
module tb_serial_subtractor;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  serial_subtractor_if #(.WIDTH(4)) bus ();

  serial_subtractor #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one op from a point just after an edge; returns cycles until done.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v,
                        input logic tbin, output int lat);
    bus.a     = ta;
    bus.b     = tb_v;
    bus.bin   = tbin;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.diff, bus.bout, bus.ovf} !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b diff=%b bout=%b ovf=%b, want all 0",
               bus.busy, bus.done, bus.diff, bus.bout, bus.ovf);
    end
  endtask

  task automatic test_basic();
    int lat;
    run_op(4'b0101, 4'b0011, 1'b0, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL basic_latency: got %0d, want 4", lat);
    end
    checks++;
    if ({bus.busy, bus.diff, bus.bout, bus.ovf} !== {1'b0, 4'b0010, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_result: got busy=%b diff=%b bout=%b ovf=%b, want busy=0 diff=0010 bout=0 ovf=0",
               bus.busy, bus.diff, bus.bout, bus.ovf);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: got done=%b one cycle later, want 0", bus.done);
    end
  endtask

  task automatic test_borrow();
    int lat;
    run_op(4'b0011, 4'b0101, 1'b0, lat);
    checks++;
    if (lat !== 4 || {bus.diff, bus.bout, bus.ovf} !== {4'b1110, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL borrow: got lat=%0d diff=%b bout=%b ovf=%b, want lat=4 diff=1110 bout=1 ovf=0",
               lat, bus.diff, bus.bout, bus.ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    int lat;
    run_op(4'b0111, 4'b1000, 1'b0, lat);
    checks++;
    if (lat !== 4 || {bus.diff, bus.bout, bus.ovf} !== {4'b1111, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL overflow: got lat=%0d diff=%b bout=%b ovf=%b, want lat=4 diff=1111 bout=1 ovf=1",
               lat, bus.diff, bus.bout, bus.ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    int gap;
    run_op(4'b0000, 4'b0000, 1'b1, lat);
    checks++;
    if (lat !== 4 || {bus.diff, bus.bout, bus.ovf} !== {4'b1111, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_first: got lat=%0d diff=%b bout=%b ovf=%b, want lat=4 diff=1111 bout=1 ovf=0",
               lat, bus.diff, bus.bout, bus.ovf);
    end
    bus.a     = 4'b1001;
    bus.b     = 4'b0001;
    bus.bin   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    gap = 1;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b after start in done cycle, want 1", bus.busy);
    end
    while (!bus.done && gap < 12) begin
      @(posedge clk); #1;
      gap++;
    end
    checks++;
    if (gap !== 5 || {bus.diff, bus.bout, bus.ovf} !== {4'b1000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_second: got gap=%0d diff=%b bout=%b ovf=%b, want gap=5 diff=1000 bout=0 ovf=0",
               gap, bus.diff, bus.bout, bus.ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    int n_done;
    logic [3:0] cap_diff;
    logic       cap_bout;
    logic       cap_ovf;
    n_done   = 0;
    cap_diff = 4'bx;
    cap_bout = 1'bx;
    cap_ovf  = 1'bx;
    bus.a     = 4'b0110;
    bus.b     = 4'b0010;
    bus.bin   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.diff !== 4'b1000) begin
      errors++;
      $display("FAIL hold_on_start: got busy=%b diff=%b, want busy=1 diff=1000", bus.busy, bus.diff);
    end
    for (int i = 0; i < 12; i++) begin
      if (bus.busy) begin
        bus.start = ~bus.start;
        bus.a     = 4'(15 - i);
        bus.b     = 4'(i);
        bus.bin   = i[0];
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.done) begin
        n_done++;
        cap_diff = bus.diff;
        cap_bout = bus.bout;
        cap_ovf  = bus.ovf;
      end
    end
    bus.start = 1'b0;
    checks++;
    if (n_done !== 1) begin
      errors++;
      $display("FAIL ignore_done_count: got %0d done pulses, want 1", n_done);
    end
    checks++;
    if ({cap_diff, cap_bout, cap_ovf} !== {4'b0100, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ignore_result: got diff=%b bout=%b ovf=%b, want diff=0100 bout=0 ovf=0",
               cap_diff, cap_bout, cap_ovf);
    end
    checks++;
    if (bus.diff !== 4'b0100) begin
      errors++;
      $display("FAIL diff_hold: got diff=%b after idle cycles, want 0100", bus.diff);
    end
  endtask

  task automatic test_abort();
    int n_done;
    bus.a     = 4'b0101;
    bus.b     = 4'b0011;
    bus.bin   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.diff, bus.bout, bus.ovf} !== 8'b0) begin
      errors++;
      $display("FAIL abort_outputs: got busy=%b done=%b diff=%b bout=%b ovf=%b, want all 0",
               bus.busy, bus.done, bus.diff, bus.bout, bus.ovf);
    end
    n_done = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.done) n_done++;
    end
    checks++;
    if (n_done !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses, want 0", n_done);
    end
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a     = 4'b0001;
    bus.b     = 4'b0000;
    @(posedge clk); #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_start_busy: got busy=%b, want 0", bus.busy);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL rst_start_idle: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_borrow();
    test_overflow();
    test_back_to_back();
    test_ignore_start();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
